// File: rtl/ysyx_25040111_lsu.sv
// Load/store and writeback stage: one executed instruction at a time, a single
// outstanding AXI4-Lite access, then a one-cycle GPR/CSR writeback and commit.
module ysyx_25040111_lsu #(
  parameter logic [3:0] LD_FAULT_CAUSE = 4'd5,
  parameter logic [3:0] ST_FAULT_CAUSE = 4'd7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        abt_valid,
  output logic        abt_ready,
  input  logic        abt_men,
  input  logic        abt_write,
  input  logic        abt_rsign,
  input  logic [1:0]  abt_mask,
  input  logic [31:0] abt_addr,
  input  logic [31:0] abt_wdata,
  input  logic [4:0]  abt_ard,
  input  logic [31:0] abt_rd,
  input  logic        abt_gen,
  input  logic [11:0] abt_acsr,
  input  logic [31:0] abt_csr,
  input  logic        abt_sen,
  input  logic [31:0] abt_pc,
  input  logic        abt_err,
  input  logic [3:0]  abt_errtp,
  output logic        abt_finish,
  output logic [4:0]  abt_frd,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        commit,
  output logic [31:0] commit_pc,
  output logic        trap,
  output logic [3:0]  trap_cause,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    WB    = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic        rsign_r, gen_r, sen_r, err_r;
  logic [1:0]  mask_r, off_r;
  logic [4:0]  ard_r;
  logic [31:0] rd_r, csr_r, pc_r;
  logic [11:0] acsr_r;
  logic [3:0]  errtp_r;

  logic        accept_s, awvalid_s, wvalid_s;
  logic        wb_load_s, wb_fault_s, wb_gen_s, wb_sen_s, wb_err_s;
  logic [31:0] wb_data_s, wb_csr_s, wb_pc_s;
  logic [4:0]  wb_ard_s;
  logic [11:0] wb_acsr_s;
  logic [3:0]  wb_errtp_s;

  function automatic logic [31:0] load_extract(input logic [31:0] data, input logic [1:0] off,
                                               input logic [1:0] mask, input logic rsign);
    logic [31:0] sh_b, sh_h, res;
    sh_b = data >> {off, 3'b000};
    sh_h = data >> {off[1], 4'b0000};
    case (mask)
      2'b01:   res = {{24{rsign & sh_b[7]}}, sh_b[7:0]};
      2'b10:   res = {{16{rsign & sh_h[15]}}, sh_h[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] off, input logic [1:0] mask);
    logic [3:0] res;
    case (mask)
      2'b01:   res = 4'b0001 << off;
      2'b10:   res = 4'b0011 << {off[1], 1'b0};
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  assign accept_s = abt_valid & abt_ready;

  // Next state, AW/W valid tracking and the values written back on entry to WB
  always_comb begin
    state_s    = state_r;
    awvalid_s  = 1'b0;
    wvalid_s   = 1'b0;
    wb_load_s  = 1'b0;
    wb_fault_s = 1'b0;
    wb_data_s  = rd_r;
    wb_ard_s   = ard_r;
    wb_gen_s   = gen_r;
    wb_sen_s   = sen_r;
    wb_acsr_s  = acsr_r;
    wb_csr_s   = csr_r;
    wb_pc_s    = pc_r;
    wb_err_s   = err_r;
    wb_errtp_s = errtp_r;
    case (state_r)
      IDLE: begin
        // A non-memory op writes back straight from the inputs to hit 1-cycle latency
        wb_data_s  = abt_rd;
        wb_ard_s   = abt_ard;
        wb_gen_s   = abt_gen;
        wb_sen_s   = abt_sen;
        wb_acsr_s  = abt_acsr;
        wb_csr_s   = abt_csr;
        wb_pc_s    = abt_pc;
        wb_err_s   = abt_err;
        wb_errtp_s = abt_errtp;
        if (!accept_s) begin
          state_s = IDLE;
        end else if (!abt_men) begin
          state_s = WB;
        end else if (abt_write) begin
          state_s   = WR_AW;
          awvalid_s = 1'b1;
          wvalid_s  = 1'b1;
        end else begin
          state_s = RD_A;
        end
      end
      RD_A: begin
        if (arready) state_s = RD_D;
        else         state_s = RD_A;
      end
      RD_D: begin
        wb_load_s  = 1'b1;
        wb_fault_s = (rresp != 2'b00);
        wb_data_s  = load_extract(rdata, off_r, mask_r, rsign_r);
        if (rvalid) state_s = WB;
        else        state_s = RD_D;
      end
      WR_AW: begin
        awvalid_s = awvalid & ~awready;
        wvalid_s  = wvalid & ~wready;
        if (!awvalid_s && !wvalid_s) state_s = WR_B;
        else                         state_s = WR_AW;
      end
      WR_B: begin
        wb_fault_s = (bresp != 2'b00);
        if (bvalid) state_s = WB;
        else        state_s = WR_B;
      end
      WB:      state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= IDLE;
      abt_ready <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      state_r   <= state_s;
      abt_ready <= (state_s == IDLE);
      arvalid   <= (state_s == RD_A);
      rready    <= (state_s == RD_D);
      awvalid   <= awvalid_s;
      wvalid    <= wvalid_s;
      bready    <= (state_s == WR_B);
    end
  end

  // Capture the instruction and drive the bus address/data on accept
  always_ff @(posedge clock) begin
    if (!reset) begin
      {rsign_r, gen_r, sen_r, err_r} <= 4'b0000;
      {mask_r, off_r} <= 4'b0000;
      ard_r   <= 5'd0;
      rd_r    <= 32'd0;
      csr_r   <= 32'd0;
      pc_r    <= 32'd0;
      acsr_r  <= 12'd0;
      errtp_r <= 4'd0;
      araddr  <= 32'd0;
      awaddr  <= 32'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
    end else if (accept_s) begin
      rsign_r <= abt_rsign;
      gen_r   <= abt_gen;
      sen_r   <= abt_sen;
      err_r   <= abt_err;
      mask_r  <= abt_mask;
      off_r   <= abt_addr[1:0];
      ard_r   <= abt_ard;
      rd_r    <= abt_rd;
      csr_r   <= abt_csr;
      pc_r    <= abt_pc;
      acsr_r  <= abt_acsr;
      errtp_r <= abt_errtp;
      araddr  <= {abt_addr[31:2], 2'b00};
      awaddr  <= {abt_addr[31:2], 2'b00};
      wdata   <= abt_wdata << {abt_addr[1:0], 3'b000};
      wstrb   <= store_strobe(abt_addr[1:0], abt_mask);
    end
  end

  // One-cycle writeback, commit and trap outputs
  always_ff @(posedge clock) begin
    if (!reset || state_s != WB) begin
      commit     <= 1'b0;
      commit_pc  <= 32'd0;
      gpr_wen    <= 1'b0;
      gpr_waddr  <= 5'd0;
      gpr_wdata  <= 32'd0;
      csr_wen    <= 1'b0;
      csr_waddr  <= 12'd0;
      csr_wdata  <= 32'd0;
      abt_finish <= 1'b0;
      abt_frd    <= 5'd0;
      trap       <= 1'b0;
      trap_cause <= 4'd0;
    end else begin
      commit     <= 1'b1;
      commit_pc  <= wb_pc_s;
      gpr_wen    <= wb_gen_s & (wb_ard_s != 5'd0) & ~wb_fault_s;
      gpr_waddr  <= wb_ard_s;
      gpr_wdata  <= wb_data_s;
      csr_wen    <= wb_sen_s;
      csr_waddr  <= wb_acsr_s;
      csr_wdata  <= wb_csr_s;
      abt_finish <= wb_load_s;
      abt_frd    <= wb_ard_s;
      trap       <= wb_err_s | wb_fault_s;
      if (wb_err_s)        trap_cause <= wb_errtp_s;
      else if (!wb_fault_s) trap_cause <= 4'd0;
      else if (wb_load_s)  trap_cause <= LD_FAULT_CAUSE;
      else                 trap_cause <= ST_FAULT_CAUSE;
    end
  end

endmodule

// File: doc/ysyx_25040111_lsu.md
Name: ysyx_25040111_lsu

Overview:
- Load/store and writeback stage directly downstream of the execute unit.
- Accepts one executed instruction per valid/ready handshake on the abt_* bundle.
- Memory instructions access data memory over a single-outstanding AXI4-Lite master; the stage then writes GPR/CSR results and reports load completion (abt_finish/abt_frd) so the execute unit releases its read-after-write lock.

Parameters:
- LD_FAULT_CAUSE, 4'd5, trap cause reported on a non-OKAY rresp
- ST_FAULT_CAUSE, 4'd7, trap cause reported on a non-OKAY bresp

Ports:
- clock in 1: single clock.
- reset in 1: synchronous, active-low.
- abt_valid in 1, abt_ready out 1: handshake from the execute unit.
- abt_men in 1: memory access; abt_write in 1 (1 = store); abt_rsign in 1 (load sign-extend).
- abt_mask in 2: 01 byte, 10 half, 11 word.
- abt_addr in 32, abt_wdata in 32: memory address and store data.
- abt_ard in 5, abt_rd in 32, abt_gen in 1: GPR target, result, write enable.
- abt_acsr in 12, abt_csr in 32, abt_sen in 1: CSR target, data, write enable.
- abt_pc in 32, abt_err in 1, abt_errtp in 4: instruction pc and upstream trap.
- abt_finish out 1, abt_frd out 5: load writeback pulse and its rd.
- gpr_wen out 1, gpr_waddr out 5, gpr_wdata out 32.
- csr_wen out 1, csr_waddr out 12, csr_wdata out 32.
- commit out 1, commit_pc out 32, trap out 1, trap_cause out 4.
- AXI read: araddr out 32, arvalid out 1, arready in 1, rdata in 32, rresp in 2, rvalid in 1, rready out 1.
- AXI write: awaddr out 32, awvalid out 1, awready in 1, wdata out 32, wstrb out 4, wvalid out 1, wready in 1, bresp in 2, bvalid in 1, bready out 1.

Behaviour:
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, WB.
- abt_ready=1 only in IDLE. All inputs are latched on the handshake; inputs are never used after that.
- Transitions from IDLE on handshake:
  - men=0 -> WB
  - men=1, write=0 -> RD_A
  - men=1, write=1 -> WR_AW
- RD_A: arvalid=1, araddr = {addr[31:2],2'b00}. On arready -> RD_D.
- RD_D: rready=1. On rvalid -> WB, latching rdata and rresp.
- WR_AW: awvalid and wvalid both asserted on entry. Each drops independently after its own handshake. When both are done -> WR_B.
- WR_B: bready=1. On bvalid -> WB, latching bresp.
- Valid signals stay asserted until their handshake completes; address and data are held stable meanwhile.
- Load extract: byte = rdata >> (8*addr[1:0]), half = rdata >> (16*addr[1]). Zero- or sign-extend per rsign. Word is taken unshifted.
- Store: wdata = abt_wdata << (8*addr[1:0]).
  - wstrb byte: 4'b0001 << addr[1:0].
  - wstrb half: 4'b0011 << {addr[1],1'b0}.
  - wstrb word: 4'b1111.
- Misaligned addresses are not checked here; the low bits are used as given.
- WB lasts exactly one cycle, then -> IDLE.
  - commit=1, commit_pc=latched pc.
  - gpr_wen = gen & (ard!=0) & ~fault. gpr_wdata = load ? extracted data : rd.
  - csr_wen = sen, unchanged by a bus fault.
  - abt_finish=1 only for loads, including faulted loads, so the execute-unit lock always clears. abt_frd = latched ard.
- trap (WB only) = abt_err | fault.
  - trap_cause = abt_err ? errtp : (load ? LD_FAULT_CAUSE : ST_FAULT_CAUSE).
  - fault = resp != 2'b00.
- Latency: non-memory writes back 1 cycle after accept. A load with 0-wait memory writes back 3 cycles after accept (AR, R, WB). A store with 0-wait memory commits 3 cycles after accept.
- Reset (reset=0 at a clock edge): state -> IDLE. All valid/ready/enable/pulse outputs, commit, trap and abt_finish = 0. Data outputs = 0. abt_ready = 1 from the first cycle after reset releases.
- Reset mid-transaction abandons the access; no writeback occurs. The slave side is reset alongside.
- One outstanding access only; no buffering. Back-to-back instructions are accepted every 2 cycles minimum.

Test Plan:
- Non-memory: ard=5, rd=0x1234, gen=1 -> one cycle later gpr_wen=1, waddr=5, wdata=0x1234, commit=1; abt_finish=0.
- lb: addr=0x80000003, rsign=1, rdata=0x80FFFFFF -> araddr=0x80000000, gpr_wdata=0xFFFFFF80, abt_finish=1, frd=ard. Same with rsign=0 -> 0x00000080.
- sh: addr=0x80000002, wdata=0xABCD -> wstrb=4'b1100, AXI wdata=0xABCD0000. awready 2 cycles before wready -> awvalid drops, wvalid holds; single commit.
- Load, rresp=2'b10, ard=7 -> gpr_wen=0, trap=1, trap_cause=5, abt_finish=1 with frd=7.
- ard=0 with gen=1 -> gpr_wen=0. abt_err=1, errtp=3, sen=1 -> csr_wen=1, trap=1, trap_cause=3.
- reset=0 asserted while in RD_D -> next cycle arvalid=rready=0, abt_ready=1 after release, no commit.
